// File: rtl/mux_4_1_arb.sv
// rtl/mux_4_1_arb.sv - 4:1 stream merge with round-robin arbitration and a registered output word
//
// Ports:
//   CLK             single clock, all state updates on the rising edge
//   RST             synchronous active-high reset
//   X0..X3          input channel data (BITS_NUM wide)
//   VALID0..VALID3  input channel i holds a word
//   READY0..READY3  channel i word accepted this cycle (at most one high)
//   Y               registered merged data
//   Y_VALID         Y holds a word
//   Y_READY         downstream accepts Y this cycle
//   SEL_OUT         source channel index of Y, drives the SEL of the far-end 1:4 demux
//
// Build option: define MUX_4_1_ARB_FIXED_PRIO_EN for fixed priority
// (channel 0 highest); otherwise round-robin starting after the last grant.

module mux_4_1_arb #(
  parameter int BITS_NUM = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [BITS_NUM-1:0] X0,
  input  logic [BITS_NUM-1:0] X1,
  input  logic [BITS_NUM-1:0] X2,
  input  logic [BITS_NUM-1:0] X3,
  input  logic                VALID0,
  input  logic                VALID1,
  input  logic                VALID2,
  input  logic                VALID3,
  output logic                READY0,
  output logic                READY1,
  output logic                READY2,
  output logic                READY3,
  output logic [BITS_NUM-1:0] Y,
  output logic                Y_VALID,
  input  logic                Y_READY,
  output logic [1:0]          SEL_OUT
);

  logic [3:0]          valid_vec;
  logic [3:0]          ready_vec;
  logic                load;
  logic                xfer_in;
  logic [1:0]          grant;
  logic                grant_ok;
  logic [BITS_NUM-1:0] grant_data;

  assign valid_vec = {VALID3, VALID2, VALID1, VALID0};

  // The output register can take a new word when empty or when its current
  // word leaves in this same cycle, which gives 1 word/cycle throughput.
  assign load = !Y_VALID || Y_READY;

`ifdef MUX_4_1_ARB_FIXED_PRIO_EN

  // Scan from the lowest priority up so the lowest valid index is written last.
  always_comb begin
    grant    = 2'd0;
    grant_ok = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (valid_vec[k]) begin
        grant    = 2'(k);
        grant_ok = 1'b1;
      end
    end
  end

`else

  logic [1:0] last;
  logic [1:0] cand;

  // Search starts one past the last granted channel; the 2-bit add wraps 3 -> 0.
  always_comb begin
    grant    = 2'd0;
    grant_ok = 1'b0;
    cand     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = last + 2'(k + 1);
      if (!grant_ok && valid_vec[cand]) begin
        grant    = cand;
        grant_ok = 1'b1;
      end
    end
  end

  // Pointer only moves on an accepted word, so a stalled request keeps its turn.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last <= 2'd3;
    end else if (xfer_in) begin
      last <= grant;
    end
  end

`endif

  // Reset gates the handshake so nothing is consumed while reset is held.
  assign ready_vec = (!RST && load && grant_ok) ? (4'b0001 << grant) : 4'b0000;
  assign xfer_in   = |ready_vec;

  assign READY0 = ready_vec[0];
  assign READY1 = ready_vec[1];
  assign READY2 = ready_vec[2];
  assign READY3 = ready_vec[3];

  always_comb begin
    grant_data = X0;
    case (grant)
      2'd0: grant_data = X0;
      2'd1: grant_data = X1;
      2'd2: grant_data = X2;
      2'd3: grant_data = X3;
      default: grant_data = X0;
    endcase
  end

  // Y and SEL_OUT only change on an input transfer; when the word drains they
  // keep their last values and only Y_VALID drops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Y       <= '0;
      SEL_OUT <= 2'd0;
      Y_VALID <= 1'b0;
    end else if (xfer_in) begin
      Y       <= grant_data;
      SEL_OUT <= grant;
      Y_VALID <= 1'b1;
    end else if (load) begin
      Y_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_4_1_arb.sv
// tb/tb_mux_4_1_arb.sv - self-checking bench for mux_4_1_arb with directed and random stimulus

module tb_mux_4_1_arb;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] x [4];
  logic [3:0]   valid;
  logic         yr;
  logic         r0, r1, r2, r3;
  logic [W-1:0] y;
  logic         yv;
  logic [1:0]   sel;

  int checks = 0;
  int errors = 0;

  int           m_last = 3;
  bit           m_yv   = 1'b0;
  logic [W-1:0] m_y    = '0;
  int           m_sel  = 0;

  always #5 clk = ~clk;

  mux_4_1_arb #(.BITS_NUM(W)) dut (
    .CLK(clk), .RST(rst),
    .X0(x[0]), .X1(x[1]), .X2(x[2]), .X3(x[3]),
    .VALID0(valid[0]), .VALID1(valid[1]), .VALID2(valid[2]), .VALID3(valid[3]),
    .READY0(r0), .READY1(r1), .READY2(r2), .READY3(r3),
    .Y(y), .Y_VALID(yv), .Y_READY(yr), .SEL_OUT(sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel the arbitration rule picks from the current requests, -1 if none.
  function automatic int pick();
    int ch;
    for (int k = 0; k < 4; k++) begin
`ifdef MUX_4_1_ARB_FIXED_PRIO_EN
      ch = k;
`else
      ch = (m_last + 1 + k) % 4;
`endif
      if (valid[ch]) return ch;
    end
    return -1;
  endfunction

  // One clock: check the handshake mid-cycle, then the registered outputs after the edge.
  task automatic cyc();
    int         g;
    bit         ld;
    logic [3:0] er;
    #1;
    ld = !m_yv || yr;
    g  = pick();
    er = 4'b0000;
    if (!rst && ld && g >= 0) er[g] = 1'b1;
    chk("ready", {r3, r2, r1, r0}, er);
    @(posedge clk);
    #1;
    if (rst) begin
      m_yv = 1'b0; m_y = '0; m_sel = 0; m_last = 3;
    end else if (er != 4'b0000) begin
      m_y = x[g]; m_sel = g; m_yv = 1'b1; m_last = g;
    end else if (ld) begin
      m_yv = 1'b0;
    end
    chk("y_valid", yv, m_yv);
    chk("y", y, m_y);
    chk("sel_out", sel, m_sel);
  endtask

  logic [W-1:0] seq_y [5];
  int           seq_s [5];

  initial begin
    seq_y = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
    seq_s = '{0, 1, 2, 3, 0};

    // Reset held two cycles with every request and downstream ready active.
    rst = 1'b1; valid = 4'b1111; yr = 1'b1;
    x[0] = 8'h10; x[1] = 8'h21; x[2] = 8'h32; x[3] = 8'h43;
    repeat (2) begin
      cyc();
      chk("rst_ready", {r3, r2, r1, r0}, 4'b0000);
      chk("rst_y_valid", yv, 1'b0);
      chk("rst_y", y, 8'h00);
      chk("rst_sel", sel, 2'd0);
    end

    // All channels requesting: one word per cycle, rotating from channel 0.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
`ifndef MUX_4_1_ARB_FIXED_PRIO_EN
      chk("seq_y", y, seq_y[i]);
      chk("seq_sel", sel, seq_s[i]);
`endif
      chk("seq_y_valid", yv, 1'b1);
    end

    // Back-pressure: single transfer, then the word is held and READY1 stays low.
    valid = 4'b0000; yr = 1'b1;
    cyc();
    valid = 4'b0010; x[1] = 8'hA5; yr = 1'b0;
    repeat (4) cyc();
    chk("hold_y", y, 8'hA5);
    chk("hold_sel", sel, 2'd1);
    chk("hold_y_valid", yv, 1'b1);
    chk("hold_ready1", r1, 1'b0);
    x[1] = 8'h5A; yr = 1'b1;
    cyc();
    chk("reload_y", y, 8'h5A);
    chk("reload_sel", sel, 2'd1);

    // Wrap-around: after channel 3, channel 0 is next in line.
    valid = 4'b0000;
    cyc();
    valid = 4'b1000; x[3] = 8'h33;
    cyc();
    chk("wrap_first_sel", sel, 2'd3);
    valid = 4'b1001; x[0] = 8'h0C;
    cyc();
    chk("wrap_sel", sel, 2'd0);
    chk("wrap_y", y, 8'h0C);
    cyc();
`ifndef MUX_4_1_ARB_FIXED_PRIO_EN
    chk("wrap_next_sel", sel, 2'd3);
    chk("wrap_next_y", y, 8'h33);
`endif

    // Reset mid-operation drops a held word and restores channel-0 priority.
    valid = 4'b0000; yr = 1'b1;
    cyc();
    valid = 4'b0100; x[2] = 8'h77; yr = 1'b0;
    cyc();
    chk("pre_rst_y_valid", yv, 1'b1);
    chk("pre_rst_sel", sel, 2'd2);
    rst = 1'b1; valid = 4'b0000;
    cyc();
    chk("mid_rst_y_valid", yv, 1'b0);
    rst = 1'b0; valid = 4'b1111; yr = 1'b1;
    x[0] = 8'h01; x[1] = 8'h02; x[2] = 8'h03; x[3] = 8'h04;
    cyc();
    chk("post_rst_sel", sel, 2'd0);
    chk("post_rst_y", y, 8'h01);

`ifdef MUX_4_1_ARB_FIXED_PRIO_EN
    // Fixed priority: channel 2 starves while channel 0 keeps requesting.
    valid = 4'b0101; yr = 1'b1;
    repeat (6) begin
      cyc();
      chk("fixed_sel", sel, 2'd0);
      chk("fixed_ready2", r2, 1'b0);
    end
`endif

    // Random traffic against the reference model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 31) == 0);
      valid = 4'($urandom);
      yr    = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) x[i] = W'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_4_1_arb.md
MUX_4_1_ARB -- requirements
Module: MUX_4_1_ARB

Interface
REQ-001 SHALL have parameter: BITS_NUM, 8, data width of every channel.
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports: X0, X1, X2, X3  input  BITS_NUM  input channel data.
REQ-005 SHALL have ports: VALID0..VALID3  input  1  input channel i holds data.
REQ-006 SHALL have ports: READY0..READY3  output  1  channel i transfer accepted this cycle.
REQ-007 SHALL have port: Y  output  BITS_NUM  registered merged data.
REQ-008 SHALL have port: Y_VALID  output  1  Y holds a word.
REQ-009 SHALL have port: Y_READY  input  1  downstream accepts Y this cycle.
REQ-010 SHALL have port: SEL_OUT  output  2  source channel index of Y; directly usable as SEL of the 1:4 demux at the far end.

Function
REQ-011 SHALL perform an input transfer on channel i when VALIDi && READYi at a rising CLK, and an output transfer when Y_VALID && Y_READY.
REQ-012 SHALL hold one word in an output register (Y, SEL_OUT, Y_VALID); LOAD = !Y_VALID || Y_READY.
REQ-013 SHALL assert READYi only when LOAD && VALIDi && i is the granted channel; at most one READY high per cycle.
REQ-014 SHALL grant round-robin: search order starts at LAST+1 mod 4 (3 wraps to 0); the first channel with VALID high wins.
REQ-015 SHALL update LAST to the granted index only on an input transfer; no transfer -> LAST unchanged.
REQ-016 SHALL load Y <= Xi, SEL_OUT <= i, Y_VALID <= 1 on an input transfer; latency is exactly 1 cycle from input transfer to Y_VALID.
REQ-017 SHALL clear Y_VALID on an output transfer with no simultaneous input transfer.
REQ-018 SHALL, on a simultaneous output and input transfer, replace the word in the same cycle; sustained throughput is 1 word/cycle.
REQ-019 SHALL keep Y and SEL_OUT stable while Y_VALID && !Y_READY; all READYi low in that state.
REQ-020 SHALL leave Y and SEL_OUT at their last values when Y_VALID is 0.
REQ-021 SHALL hold all READYi low when no VALIDi is high; no spurious grant.

Reset
REQ-022 SHALL, on RST high at a rising CLK, set Y_VALID=0, Y=0, SEL_OUT=0, LAST=3 so channel 0 has first priority.
REQ-023 SHALL hold all READYi low in every cycle where RST is high, regardless of VALIDi or Y_READY.
REQ-024 SHALL discard any held output word when reset is applied mid-operation; no input is transferred during reset.

Configuration
REQ-025 SHALL use macro MUX_4_1_ARB_FIXED_PRIO_EN.
REQ-026 SHALL, when the macro is defined, grant by fixed priority (channel 0 highest, 3 lowest) and omit LAST.
REQ-027 SHALL, when the macro is undefined, use the round-robin arbitration of REQ-014/REQ-015; all other requirements are identical in both builds.

Verification (BITS_NUM=8)
REQ-028 SHALL cover: RST high 2 cycles with all VALIDi=1, Y_READY=1 -> READY0..3=0, Y_VALID=0, Y=8'h00, SEL_OUT=0 throughout.
REQ-029 SHALL cover: after reset, all VALIDi=1, X0..X3=8'h10,8'h21,8'h32,8'h43, Y_READY=1 -> Y_VALID rises 1 cycle after release; Y/SEL_OUT sequence 10/0, 21/1, 32/2, 43/3, 10/0 on consecutive cycles.
REQ-030 SHALL cover: VALID1=1, X1=8'hA5, Y_READY=0 for 4 cycles -> one transfer, then Y=A5, SEL_OUT=1, Y_VALID=1 held and READY1=0; Y_READY=1 one cycle -> next word loaded same cycle.
REQ-031 SHALL cover: wrap-around, only VALID3 (X3=8'h33) for one transfer, then VALID0=VALID3=1 (X0=8'h0C) -> next grant channel 0 (SEL_OUT=0, Y=0C), then channel 3.
REQ-032 SHALL cover: RST asserted one cycle while Y_VALID=1, Y_READY=0 -> Y_VALID=0 next cycle, word lost; first grant after release is channel 0.
REQ-033 SHALL cover: MUX_4_1_ARB_FIXED_PRIO_EN defined, VALID0=VALID2=1 held, Y_READY=1 -> SEL_OUT=0 every cycle, READY2 never high.
